multicycle_ctrl: RTL

- Moore/Mealy control sequencer for the multi-cycle RV32I core.
- Drives the register file write enable, IR latch, PC update, PC-source select, writeback mux and data-memory handshake from the instruction in the IR.
- Replaces the ad-hoc alternate-edge PC toggle. Halts on a write to the finish register, an illegal opcode or a data-memory timeout.
- Exposes cycle and retired-instruction counters.

---
 rtl/core_pkg.sv | 40 ++++
 rtl/multicycle_ctrl_if.sv | 31 +++
 rtl/multicycle_ctrl_opcode_class.sv | 17 +
 rtl/multicycle_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: opcode, state, writeback-select and halt-cause encodings for the multi-cycle core
package core_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [1:0] HALT_NONE    = 2'd0;
    localparam logic [1:0] HALT_FINISH  = 2'd1;
    localparam logic [1:0] HALT_ILLEGAL = 2'd2;
    localparam logic [1:0] HALT_TIMEOUT = 2'd3;

    typedef struct packed {
        logic is_branch;
        logic is_mem;
        logic is_store;
        logic is_load;
        logic is_jump;
        logic writes_rd;
        logic illegal;
    } op_class_t;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: IR fields and datapath/memory strobes between the controller and the datapath
interface multicycle_ctrl_if;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic        w_br_taken;
    logic        w_dmem_ack;
    logic        w_ir_we;
    logic        w_pc_we;
    logic        w_pc_sel;
    logic        w_rf_we;
    logic [1:0]  w_wb_sel;
    logic        w_dmem_req;
    logic        w_dmem_we;
    logic        w_halted;
    logic [1:0]  w_halt_cause;
    logic [2:0]  w_state;
    logic [31:0] w_cycles;
    logic [31:0] w_instret;

    modport master (
        input  w_opcode, w_rd, w_br_taken, w_dmem_ack,
        output w_ir_we, w_pc_we, w_pc_sel, w_rf_we, w_wb_sel, w_dmem_req, w_dmem_we,
               w_halted, w_halt_cause, w_state, w_cycles, w_instret
    );

    modport slave (
        output w_opcode, w_rd, w_br_taken, w_dmem_ack,
        input  w_ir_we, w_pc_we, w_pc_sel, w_rf_we, w_wb_sel, w_dmem_req, w_dmem_we,
               w_halted, w_halt_cause, w_state, w_cycles, w_instret
    );
endinterface

// File: rtl/multicycle_ctrl_opcode_class.sv
// opcode_class: classifies an RV32I opcode into the groups the sequencer branches on
module opcode_class
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls
);
    logic br, ld, st, jmp, wr;

    assign br  = opcode == OP_BRANCH;
    assign ld  = opcode == OP_LOAD;
    assign st  = opcode == OP_STORE;
    assign jmp = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign wr  = ld || jmp || (opcode == OP_OP) || (opcode == OP_IMM) ||
                 (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign cls = {br, ld || st, st, ld, jmp, wr, !(br || ld || st || wr)};
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with halt detection and perf counters
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int HALT_REG    = 30
) (
    input logic                w_clk,
    input logic                w_rst,
    multicycle_ctrl_if.master  bus
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t      state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] instret_q, instret_d;
    logic        pc_we;
    op_class_t   cls;

    opcode_class u_cls (.opcode(bus.w_opcode), .cls(cls));

    // State, halt cause, MEM wait counter and performance counters
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q   <= S_FETCH;
            cause_q   <= HALT_NONE;
            tmo_q     <= '0;
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            tmo_q     <= tmo_d;
            cycles_q  <= cycles_d;
            instret_q <= instret_d;
        end
    end

    // Next state; an ack in the last allowed MEM cycle takes priority over the timeout
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (cls.is_branch) begin
                    state_d = S_FETCH;
                end else if (cls.is_mem) begin
                    state_d = S_MEM;
                    tmo_d   = '0;
                end else if (cls.illegal) begin
                    state_d = S_HALT;
                    cause_d = HALT_ILLEGAL;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.w_dmem_ack) begin
                    state_d = cls.is_store ? S_FETCH : S_WB;
                end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
                    state_d = S_HALT;
                    cause_d = HALT_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WB: begin
                state_d = (bus.w_rd == 5'(HALT_REG)) ? S_HALT : S_FETCH;
                cause_d = (bus.w_rd == 5'(HALT_REG)) ? HALT_FINISH : cause_q;
            end
            default: ;
        endcase
    end

    // Strobes decoded from the state, IR fields and datapath/memory inputs; counters advance
    always_comb begin
        pc_we = ((state_q == S_EXEC) && cls.is_branch) ||
                ((state_q == S_MEM) && bus.w_dmem_ack && cls.is_store) ||
                (state_q == S_WB);
        bus.w_ir_we      = state_q == S_DECODE;
        bus.w_pc_we      = pc_we;
        bus.w_pc_sel     = ((state_q == S_EXEC) && cls.is_branch && bus.w_br_taken) ||
                           ((state_q == S_WB) && cls.is_jump);
        bus.w_rf_we      = (state_q == S_WB) && cls.writes_rd && (bus.w_rd != 5'd0);
        bus.w_wb_sel     = (state_q != S_WB) ? WB_ALU :
                           cls.is_load ? WB_LOAD : cls.is_jump ? WB_PC4 : WB_ALU;
        bus.w_dmem_req   = state_q == S_MEM;
        bus.w_dmem_we    = (state_q == S_MEM) && cls.is_store;
        bus.w_halted     = state_q == S_HALT;
        bus.w_halt_cause = cause_q;
        bus.w_state      = state_q;
        bus.w_cycles     = cycles_q;
        bus.w_instret    = instret_q;
        cycles_d         = (state_q != S_HALT) ? cycles_q + 32'd1 : cycles_q;
        instret_d        = pc_we ? instret_q + 32'd1 : instret_q;
    end
endmodule
